// File: rtl/nv_pipe_pkg.sv
// Shared types and helpers for the nv_pipe retiming buffer.
// Stage state encoding doubles as {skid_vld, main_vld}.
package nv_pipe_pkg;

  localparam int MAX_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_st_e;

  function automatic int calc_cw(input int depth);
    if (depth == 0) return 1;
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/nv_pipe_skid_stage.sv
// One registered valid/ready skid stage: main + skid entry.
// Ports: clk/rstn, flush, in_* upstream, out_* downstream, vld_cnt.
module nv_pipe_skid_stage
  import nv_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [WIDTH-1:0] out_pd,
  output logic [1:0]       vld_cnt
);

  stage_st_e        st;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             take;

  // State bits are the valid flags: bit0 main, bit1 skid.
  assign out_pvld = st[0];
  assign out_pd   = main_data;
  assign in_prdy  = ~st[1];
  assign vld_cnt  = {st[1] & st[0], st[1] ^ st[0]};

  assign accept = in_pvld & in_prdy;
  assign take   = out_pvld & out_prdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= ST_EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      st <= ST_EMPTY;
    end else begin
      unique case (st)
        ST_EMPTY: begin
          if (accept) begin
            st        <= ST_ONE;
            main_data <= in_pd;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_data <= in_pd;
          end else if (accept) begin
            st        <= ST_FULL;
            skid_data <= in_pd;
          end else if (take) begin
            st <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            st        <= ST_ONE;
            main_data <= skid_data;
          end
        end
        default: st <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/nv_pipe_buffer.sv
// Chain of DEPTH skid stages with occupancy count; DEPTH=0 is a wire.
// Ports: nvdla clock/reset, in_* upstream, out_* downstream, flush, occupancy.
module nv_pipe_buffer
  import nv_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = calc_cw(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [WIDTH-1:0] out_pd,
  input  logic             flush,
  output logic [CW-1:0]    occupancy
);

  if (DEPTH == 0) begin : g_bypass
    assign out_pvld  = in_pvld;
    assign out_pd    = in_pd;
    assign in_prdy   = out_prdy;
    assign occupancy = '0;
  end else begin : g_chain
    logic [DEPTH:0]   vld;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] pd  [DEPTH+1];
    logic [1:0]       cnt [DEPTH];
    logic [CW-1:0]    occ_sum;

    assign vld[0]     = in_pvld;
    assign pd[0]      = in_pd;
    assign in_prdy    = rdy[0];
    assign out_pvld   = vld[DEPTH];
    assign out_pd     = pd[DEPTH];
    assign rdy[DEPTH] = out_prdy;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      nv_pipe_skid_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk     (nvdla_core_clk),
        .rstn    (nvdla_core_rstn),
        .flush   (flush),
        .in_pvld (vld[k]),
        .in_prdy (rdy[k]),
        .in_pd   (pd[k]),
        .out_pvld(vld[k+1]),
        .out_prdy(rdy[k+1]),
        .out_pd  (pd[k+1]),
        .vld_cnt (cnt[k])
      );
    end

    always_comb begin
      occ_sum = '0;
      for (int i = 0; i < DEPTH; i++) begin
        occ_sum = occ_sum + CW'(cnt[i]);
      end
    end

    assign occupancy = occ_sum;
  end

endmodule
